// File: rtl/mask_match_sequencer_if.sv
// mask_match_sequencer_if: handshake and data bundle between mask fetch, the sequencer and PE operand select
//   slave  : sequencer side (takes ivalid/bitmasks/iready, drives oready/ovalid/beat fields/counts)
//   master : environment side (mirror of slave)
interface mask_match_sequencer_if #(
  parameter int MASK_LENGTH    = 16,
  parameter int INDEX_BITWIDTH = 5,
  parameter int POS_BITWIDTH   = 4,
  parameter int LANES          = 4
);
  logic                            ivalid;
  logic                            oready;
  logic                            ovalid;
  logic                            iready;
  logic [MASK_LENGTH-1:0]          bitmaskW;
  logic [MASK_LENGTH-1:0]          bitmaskA;
  logic [LANES-1:0]                laneValid;
  logic [LANES*POS_BITWIDTH-1:0]   wIndex;
  logic [LANES*POS_BITWIDTH-1:0]   aIndex;
  logic                            lastBeat;
  logic [INDEX_BITWIDTH-1:0]       numW;
  logic [INDEX_BITWIDTH-1:0]       numA;
  logic [INDEX_BITWIDTH-1:0]       numMutual;
  modport slave (
    input  ivalid, iready, bitmaskW, bitmaskA,
    output oready, ovalid, laneValid, wIndex, aIndex, lastBeat, numW, numA, numMutual
  );
  modport master (
    output ivalid, iready, bitmaskW, bitmaskA,
    input  oready, ovalid, laneValid, wIndex, aIndex, lastBeat, numW, numA, numMutual
  );
endinterface

// File: rtl/mask_match_sequencer.sv
// mask_match_sequencer: streams matched W/A positions of a mask pair as beats of up to LANES dense-index pairs
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : mask_match_sequencer_if.slave (input handshake + masks, output beats + popcounts)
module mask_match_sequencer #(
  parameter int MASK_LENGTH    = 16,
  parameter int INDEX_BITWIDTH = 5,
  parameter int POS_BITWIDTH   = 4,
  parameter int LANES          = 4
) (
  input logic                   clock,
  input logic                   resetn,
  mask_match_sequencer_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t                          state_q, state_d;
  logic [MASK_LENGTH-1:0]          w_q, w_d, a_q, a_d, rem_q, rem_d, sel_q, sel_d;
  logic [LANES-1:0]                lv_q, lv_d;
  logic [LANES*POS_BITWIDTH-1:0]   wi_q, wi_d, ai_q, ai_d;
  logic                            last_q, last_d;
  logic [INDEX_BITWIDTH-1:0]       nw_q, nw_d, na_q, na_d, nm_q, nm_d;
  logic [INDEX_BITWIDTH-1:0]       r;
  logic [POS_BITWIDTH-1:0]         wc, ac;
  logic                            accept, hs, upd;

  function automatic logic [INDEX_BITWIDTH-1:0] popcnt(input logic [MASK_LENGTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < MASK_LENGTH; i++) popcnt += INDEX_BITWIDTH'(v[i]);
  endfunction

  assign hs           = bus.ovalid && bus.iready;
  assign bus.ovalid   = state_q == EMIT;
  // the last-beat handshake frees the block in the same cycle so a waiting pair loads without a bubble
  assign bus.oready   = resetn && (state_q == IDLE || (hs && last_q));
  assign accept       = bus.ivalid && bus.oready;
  assign upd          = accept || hs;
  assign bus.laneValid = lv_q;
  assign bus.wIndex    = wi_q;
  assign bus.aIndex    = ai_q;
  assign bus.lastBeat  = last_q;
  assign bus.numW      = nw_q;
  assign bus.numA      = na_q;
  assign bus.numMutual = nm_q;

  always_comb begin
    state_d = accept ? EMIT : (hs && last_q) ? IDLE : state_q;
    w_d     = accept ? bus.bitmaskW : w_q;
    a_d     = accept ? bus.bitmaskA : a_q;
    rem_d   = accept ? (bus.bitmaskW & bus.bitmaskA) : hs ? (rem_q & ~sel_q) : rem_q;
    nw_d    = accept ? popcnt(bus.bitmaskW) : nw_q;
    na_d    = accept ? popcnt(bus.bitmaskA) : na_q;
    nm_d    = accept ? popcnt(bus.bitmaskW & bus.bitmaskA) : nm_q;
    lv_d    = '0;
    wi_d    = '0;
    ai_d    = '0;
    sel_d   = '0;
    r       = '0;
    wc      = '0;
    ac      = '0;
    // r ranks each remaining bit; the first LANES ranks map straight onto lanes 0..LANES-1
    for (int i = 0; i < MASK_LENGTH; i++) begin
      for (int l = 0; l < LANES; l++) begin
        if (rem_d[i] && r == INDEX_BITWIDTH'(l)) begin
          lv_d[l]                                = 1'b1;
          wi_d[l*POS_BITWIDTH +: POS_BITWIDTH]   = wc;
          ai_d[l*POS_BITWIDTH +: POS_BITWIDTH]   = ac;
        end
      end
      sel_d[i] = rem_d[i] && r < INDEX_BITWIDTH'(LANES);
      r        = r + INDEX_BITWIDTH'(rem_d[i]);
      wc       = wc + POS_BITWIDTH'(w_d[i]);
      ac       = ac + POS_BITWIDTH'(a_d[i]);
    end
    last_d = r <= INDEX_BITWIDTH'(LANES);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      w_q     <= '0;
      a_q     <= '0;
      rem_q   <= '0;
      sel_q   <= '0;
      lv_q    <= '0;
      wi_q    <= '0;
      ai_q    <= '0;
      last_q  <= 1'b0;
      nw_q    <= '0;
      na_q    <= '0;
      nm_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      nw_q    <= nw_d;
      na_q    <= na_d;
      nm_q    <= nm_d;
      if (upd) begin
        sel_q  <= sel_d;
        lv_q   <= lv_d;
        wi_q   <= wi_d;
        ai_q   <= ai_d;
        last_q <= last_d;
      end
    end
  end
endmodule

// File: tb/tb_mask_match_sequencer.sv
// tb_mask_match_sequencer: randomized and directed checks of mask_match_sequencer against a position-list model
module tb_mask_match_sequencer;
  localparam int ML = 16;
  localparam int IB = 5;
  localparam int P  = 4;
  localparam int L  = 4;

  typedef struct packed {
    logic [L-1:0]   lv;
    logic [L*P-1:0] wi;
    logic [L*P-1:0] ai;
    logic           last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rstn;
  int    checks = 0;
  int    fails  = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mask_match_sequencer_if #(.MASK_LENGTH(ML), .INDEX_BITWIDTH(IB), .POS_BITWIDTH(P), .LANES(L)) bus ();

  mask_match_sequencer #(.MASK_LENGTH(ML), .INDEX_BITWIDTH(IB), .POS_BITWIDTH(P), .LANES(L)) dut (
    .clock  (clk),
    .resetn (rstn),
    .bus    (bus)
  );

  function automatic beat_t cur_beat();
    return {bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat};
  endfunction

  // lists the matched positions, chunks them L at a time, and ranks each by counting lower W/A bits
  function automatic void model(input logic [ML-1:0] w, input logic [ML-1:0] a);
    int pos[$];
    int nb;
    beat_t b;
    logic [ML-1:0] one, low;
    one = 1;
    for (int p = 0; p < ML; p++) if (w[p] && a[p]) pos.push_back(p);
    nb = pos.size() == 0 ? 1 : (pos.size() + L - 1) / L;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int l = 0; l < L; l++) begin
        if (k * L + l < pos.size()) begin
          low              = (one << pos[k*L+l]) - one;
          b.lv[l]          = 1'b1;
          b.wi[l*P +: P]   = P'($countones(w & low));
          b.ai[l*P +: P]   = P'($countones(a & low));
        end
      end
      b.last = k == nb - 1;
      exp_q.push_back(b);
    end
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    bus.ivalid = 1'b0;
    bus.iready = 1'b0;
    bus.bitmaskW = '0;
    bus.bitmaskA = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.ovalid, bus.oready, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual} !== '0) begin
      fails++;
      $display("FAIL reset_state got ovalid=%b oready=%b lv=%b wi=%h ai=%h last=%b nw=%0d na=%0d nm=%0d exp all 0",
               bus.ovalid, bus.oready, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.oready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_oready got %b exp 1", bus.oready);
    end
  endtask

  task automatic test_pair(input logic [ML-1:0] w, input logic [ML-1:0] a, input int stall);
    beat_t e, g;
    int cyc;
    logic [IB-1:0] ew, ea, em;
    model(w, a);
    ew = IB'($countones(w));
    ea = IB'($countones(a));
    em = IB'($countones(w & a));
    bus.bitmaskW = w;
    bus.bitmaskA = a;
    bus.ivalid = 1'b1;
    bus.iready = 1'b0;
    #1;
    cyc = 0;
    while (!bus.oready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!bus.oready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout w=%h a=%h got oready=%b exp 1", w, a, bus.oready);
    end
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.iready = $urandom_range(99) >= stall;
      #1;
      checks++;
      if (bus.ovalid !== 1'b1) begin
        fails++;
        $display("FAIL ovalid_gap w=%h a=%h got ovalid=%b exp 1", w, a, bus.ovalid);
      end else if (bus.iready) begin
        e = exp_q.pop_front();
        g = cur_beat();
        checks++;
        if (g !== e) begin
          fails++;
          $display("FAIL beat w=%h a=%h got lv=%b wi=%h ai=%h last=%b exp lv=%b wi=%h ai=%h last=%b",
                   w, a, g.lv, g.wi, g.ai, g.last, e.lv, e.wi, e.ai, e.last);
        end
        checks++;
        if ({bus.numW, bus.numA, bus.numMutual} !== {ew, ea, em}) begin
          fails++;
          $display("FAIL counts w=%h a=%h got %0d/%0d/%0d exp %0d/%0d/%0d",
                   w, a, bus.numW, bus.numA, bus.numMutual, ew, ea, em);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout w=%h a=%h got %0d beats left exp 0", w, a, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    bus.iready = 1'b0;
    #1;
    checks++;
    if ({bus.ovalid, bus.oready} !== 2'b01) begin
      fails++;
      $display("FAIL idle_after w=%h a=%h got ovalid=%b oready=%b exp 0 1", w, a, bus.ovalid, bus.oready);
    end
  endtask

  task automatic test_directed();
    test_pair(16'hFFFF, 16'h00F0, 0);
    test_pair(16'h5555, 16'hFFFF, 0);
    test_pair(16'h000F, 16'h00F0, 0);
  endtask

  task automatic test_backpressure();
    beat_t e;
    logic [3*IB:0] snap_c;
    beat_t snap;
    int n;
    model(16'h5555, 16'hFFFF);
    e = exp_q.pop_front();
    exp_q.delete();
    bus.bitmaskW = 16'h5555;
    bus.bitmaskA = 16'hFFFF;
    bus.ivalid = 1'b1;
    bus.iready = 1'b0;
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    @(negedge clk);
    #1;
    snap = cur_beat();
    snap_c = {bus.ovalid, bus.numW, bus.numA, bus.numMutual};
    checks++;
    if (snap !== e || snap_c !== {1'b1, 5'd8, 5'd16, 5'd8}) begin
      fails++;
      $display("FAIL stall_beat0 got lv=%b wi=%h ai=%h last=%b c=%h exp lv=%b wi=%h ai=%h last=%b",
               snap.lv, snap.wi, snap.ai, snap.last, snap_c, e.lv, e.wi, e.ai, e.last);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (cur_beat() !== snap || {bus.ovalid, bus.numW, bus.numA, bus.numMutual} !== snap_c || bus.oready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold got beat=%h c=%h oready=%b exp beat=%h c=%h oready=0",
                 cur_beat(), {bus.ovalid, bus.numW, bus.numA, bus.numMutual}, bus.oready, snap, snap_c);
      end
    end
    bus.iready = 1'b1;
    n = int'(bus.ovalid);
    repeat (5) begin
      @(negedge clk);
      #1;
      n += int'(bus.ovalid);
    end
    bus.iready = 1'b0;
    checks++;
    if (n != 2) begin
      fails++;
      $display("FAIL stall_handshakes got %0d exp 2", n);
    end
  endtask

  task automatic test_back_to_back();
    bus.bitmaskW = 16'hFFFF;
    bus.bitmaskA = 16'h00F0;
    bus.ivalid = 1'b1;
    bus.iready = 1'b1;
    @(posedge clk);
    #1;
    bus.bitmaskW = 16'h000F;
    bus.bitmaskA = 16'h00F0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.ovalid, bus.oready, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual}
        !== {1'b1, 1'b1, 4'b1111, 16'h7654, 16'h3210, 1'b1, 5'd16, 5'd4, 5'd4}) begin
      fails++;
      $display("FAIL b2b_first got ov=%b or=%b lv=%b wi=%h ai=%h last=%b n=%0d/%0d/%0d exp 1 1 1111 7654 3210 1 16/4/4",
               bus.ovalid, bus.oready, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual);
    end
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.ovalid, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual}
        !== {1'b1, 4'b0000, 16'h0, 16'h0, 1'b1, 5'd4, 5'd4, 5'd0}) begin
      fails++;
      $display("FAIL b2b_second got ov=%b lv=%b wi=%h ai=%h last=%b n=%0d/%0d/%0d exp 1 0000 0 0 1 4/4/0",
               bus.ovalid, bus.laneValid, bus.wIndex, bus.aIndex, bus.lastBeat, bus.numW, bus.numA, bus.numMutual);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.ovalid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end got ovalid=%b exp 0", bus.ovalid);
    end
    bus.iready = 1'b0;
  endtask

  task automatic test_reset_mid_emit();
    int seen;
    bus.bitmaskW = 16'h5555;
    bus.bitmaskA = 16'hFFFF;
    bus.ivalid = 1'b1;
    bus.iready = 1'b0;
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.ovalid !== 1'b1) begin
      fails++;
      $display("FAIL mid_beat0 got ovalid=%b exp 1", bus.ovalid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.oready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_oready got %b exp 0", bus.oready);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if ({bus.ovalid, bus.oready, bus.laneValid, bus.lastBeat, bus.numMutual} !== {1'b0, 1'b1, 4'b0, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL mid_after got ov=%b or=%b lv=%b last=%b nm=%0d exp 0 1 0000 0 0",
               bus.ovalid, bus.oready, bus.laneValid, bus.lastBeat, bus.numMutual);
    end
    bus.iready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      seen += int'(bus.ovalid);
    end
    bus.iready = 1'b0;
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_residual got %0d beats exp 0", seen);
    end
    test_pair(16'hFFFF, 16'hFFFF, 20);
  endtask

  task automatic test_random();
    logic [ML-1:0] w, a;
    for (int t = 0; t < 40; t++) begin
      w = ML'($urandom);
      a = ML'($urandom);
      if ($urandom_range(3) == 0) w = w & ML'($urandom);
      if ($urandom_range(3) == 0) a = a | ML'($urandom);
      if ($urandom_range(9) == 0) a = ~w;
      test_pair(w, a, 30);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mask_match_sequencer.md
Name: mask_match_sequencer

Overview:
- Streaming successor to the single-cycle mask matcher, parametrised in mask length and lane count.
- Accepts one weight/activation bitmask pair per transaction and forms the mutual mask (W & A).
- Emits the matched pairs over one or more output beats, up to LANES pairs per beat. Each pair carries its dense index in the W stream and its dense index in the A stream.
- Sits between the mask-fetch stage and the PE operand-select logic. Handshake is ivalid/iready/ovalid/oready.

Parameters:
- MASK_LENGTH, 16, bits per bitmask.
- INDEX_BITWIDTH, 5, width of the count outputs; must be >= clog2(MASK_LENGTH+1).
- POS_BITWIDTH, 4, width of each dense-index lane; must be >= clog2(MASK_LENGTH).
- LANES, 4, maximum matched pairs per output beat; 1 <= LANES <= MASK_LENGTH.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- resetn, input, 1, synchronous active-low reset.
- ivalid, input, 1, upstream presents bitmaskW/bitmaskA.
- oready, output, 1, block can accept an input this cycle.
- ovalid, output, 1, output beat valid.
- iready, input, 1, downstream accepts the output beat.
- bitmaskW, input, MASK_LENGTH, weight mask, little endian (bit 0 is the first element).
- bitmaskA, input, MASK_LENGTH, activation mask, little endian.
- laneValid, output, LANES, per-lane valid; lane 0 holds the lowest position.
- wIndex, output, LANES*POS_BITWIDTH, dense index within the W stream, per lane.
- aIndex, output, LANES*POS_BITWIDTH, dense index within the A stream, per lane.
- lastBeat, output, 1, marks the final beat of the current mask pair.
- numW, output, INDEX_BITWIDTH, popcount of bitmaskW.
- numA, output, INDEX_BITWIDTH, popcount of bitmaskA.
- numMutual, output, INDEX_BITWIDTH, popcount of the mutual mask.

Behaviour:
- Reset: while resetn=0 at a clock edge, the block enters IDLE and clears ovalid, laneValid, wIndex, aIndex, lastBeat and all counts to 0. oready=0 while resetn=0.
- A reset asserted mid-EMIT discards the pair; no residual beat is emitted after release.
- States:
  - IDLE: ovalid=0, oready=1.
  - EMIT: ovalid=1.
- Input accept occurs when ivalid && oready.
  - The block registers W, A, remaining = W & A, and numW/numA/numMutual.
  - It then moves to EMIT. The first beat is valid on the next cycle (latency 1).
- oready = (state==IDLE) || (ovalid && iready && lastBeat). A back-to-back accept keeps the output stream free of bubbles.
- Beat contents are registered, derived from the remaining mask:
  - Select the lowest min(LANES, popcount(remaining)) set positions p, in ascending order, into lanes 0.., with laneValid=1.
  - wIndex = number of W bits set at positions < p.
  - aIndex = number of A bits set at positions < p.
  - Unused lanes: laneValid=0, indices=0.
  - lastBeat=1 iff popcount(remaining) <= LANES.
- Output handshake occurs when ovalid && iready.
  - The selected bits are cleared from remaining.
  - If lastBeat: go to IDLE, or load the new pair if accepted in the same cycle.
  - Otherwise present the next beat on the next cycle.
- Backpressure: while ovalid && !iready, every output holds stable and no state changes.
- Empty mutual mask: exactly one beat with laneValid=0, lastBeat=1 and valid counts. Every input produces at least one beat.
- Beats per pair = max(1, ceil(numMutual/LANES)).
- numW, numA and numMutual hold constant across all beats of a pair.
- Full masks: all-ones W and A give numMutual=MASK_LENGTH, which must not overflow INDEX_BITWIDTH.
- ivalid is ignored when oready=0. Upstream holds its data until the handshake completes.

Test Plan:
1. W=0xFFFF, A=0x00F0 -> one beat:
   - laneValid=4'b1111, wIndex={7,6,5,4}, aIndex={3,2,1,0}, lastBeat=1.
   - numW=16, numA=4, numMutual=4.
2. W=0x5555, A=0xFFFF -> two beats:
   - Beat0: wIndex={3,2,1,0}, aIndex={6,4,2,0}, lastBeat=0.
   - Beat1: wIndex={7,6,5,4}, aIndex={14,12,10,8}, lastBeat=1.
   - numMutual=8.
3. W=0x000F, A=0x00F0 -> one beat: laneValid=0, lastBeat=1, numW=4, numA=4, numMutual=0.
4. Case 2 with iready=0 for 3 cycles during beat0 -> outputs bit-stable, oready=0; after release, beat1 follows and there are exactly 2 handshakes.
5. Back-to-back: case 1 then case 3 with ivalid held high -> second pair accepted in the same cycle as the case-1 last-beat handshake; ovalid stays continuously 1.
6. Reset mid-EMIT: resetn=0 for 1 cycle during beat0 of case 2 -> ovalid=0 next cycle and oready=1 after release; no beat1 appears. Then W=A=0xFFFF -> 4 beats, numMutual=16.
